fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection with one branch delay slot, and
// the F->D pipeline register.
// Optional build macro FETCH_ADEL_CHECK_EN enables the fetch address check.
// When it is enabled, a misaligned or out-of-range fetch loads a faulting
// bubble into D: D_exc=1, D_instr=0, D_valid=1.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic [31:0] jr_target,
    output logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [15:0] D_imm16,
    output logic        D_valid,
    output logic        D_exc
);

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JREG   = 2'b11;

    localparam logic [31:0] IMEM_LO = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI = 32'h0000_6FFC;

    logic [31:0] f_pc_q,    f_pc_d;
    logic [31:0] d_instr_q;
    logic [31:0] d_pc_q;
    logic        d_valid_q;

    logic [31:0] f_pc4;
    logic [31:0] d_pc4;
    logic [31:0] fetch_instr;
    logic        fetch_exc;

    assign f_pc4 = f_pc_q + 32'd4;
    assign d_pc4 = d_pc_q + 32'd4;

    // Redirects use the held D-stage PC and instruction. Those values do not
    // change during a stall, so the selected target stays stable.
    always_comb begin
        // NOTE: assign a default before the case so that every path drives
        // f_pc_d; a missing assignment would infer a latch.
        f_pc_d = f_pc4;
        case (npc_sel)
            NPC_SEQ:    f_pc_d = f_pc4;
            NPC_BRANCH: f_pc_d = br_taken ? (d_pc4 + (br_offset << 2)) : f_pc4;
            NPC_JUMP:   f_pc_d = {d_pc4[31:28], d_instr_q[25:0], 2'b00};
            NPC_JREG:   f_pc_d = jr_target;
            default:    f_pc_d = f_pc4;
        endcase
    end

`ifdef FETCH_ADEL_CHECK_EN
    logic d_exc_q;

    // Address check. A faulting fetch never hands its memory word to decode.
    always_comb begin
        fetch_exc   = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IMEM_LO) || (f_pc_q > IMEM_HI);
        fetch_instr = fetch_exc ? 32'h0000_0000 : i_data;
    end

    assign D_exc = d_exc_q;
`else
    // Without the check, the instruction word passes through unchanged and the
    // flag is tied low.
    always_comb begin
        fetch_exc   = 1'b0;
        fetch_instr = i_data;
    end

    assign D_exc = 1'b0;
`endif

    // PC and F->D register. Priority: reset, then stall (hold), then flush
    // (bubble), then normal advance. The PC still advances during a flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // right-hand side reads the value from before the edge.
        // d_pc_q therefore captures the old f_pc_q.
        if (reset) begin
            f_pc_q    <= PC_RESET;
            d_instr_q <= 32'h0000_0000;
            d_pc_q    <= 32'h0000_0000;
            d_valid_q <= 1'b0;
        end else if (!stall) begin
            f_pc_q <= f_pc_d;
            d_pc_q <= f_pc_q;
            if (flush) begin
                d_instr_q <= 32'h0000_0000;
                d_valid_q <= 1'b0;
            end else begin
                d_instr_q <= fetch_instr;
                d_valid_q <= 1'b1;
            end
        end
    end

`ifdef FETCH_ADEL_CHECK_EN
    // Exception flag follows the same hold/bubble rules as D_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_exc_q <= 1'b0;
        end else if (!stall) begin
            d_exc_q <= flush ? 1'b0 : fetch_exc;
        end
    end
`endif

    assign i_addr  = f_pc_q;
    assign D_instr = d_instr_q;
    assign D_pc    = d_pc_q;
    assign D_imm16 = d_instr_q[15:0];
    assign D_valid = d_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// The instruction memory is a combinational model:
// - address 3010 holds the jump word 0800_1000;
// - every other address returns addr ^ C0DE_0000.
// Build with +define+FETCH_ADEL_CHECK_EN to exercise the address check.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] br_offset;
    logic [31:0] jr_target;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [15:0] D_imm16;
    logic        D_valid;
    logic        D_exc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0000_3010) ? 32'h0800_1000 : (a ^ 32'hC0DE_0000);
    endfunction

    assign i_data = mem(i_addr);

    fetch_stage #(.PC_RESET(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .jr_target (jr_target),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .D_instr   (D_instr),
        .D_pc      (D_pc),
        .D_imm16   (D_imm16),
        .D_valid   (D_valid),
        .D_exc     (D_exc)
    );

    // Inputs change 1 time unit after posedge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        npc_sel = 2'b00; br_taken = 1'b0;
        br_offset = 32'h0; jr_target = 32'h0;
    endtask

    // Reset for one cycle, then take k sequential steps.
    // Afterwards F = 3000+4k and D_pc = 3000+4(k-1).
    task automatic restart(input int k);
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        tick(); tick();
        idle_inputs();
        checks++; if (i_addr !== 32'h3000) begin errors++; $display("FAIL reset_iaddr: got %h want 00003000", i_addr); end
        checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", D_valid); end
        checks++; if (D_pc !== 32'h0 || D_instr !== 32'h0 || D_exc !== 1'b0) begin errors++; $display("FAIL reset_dregs: pc %h instr %h exc %b want 0 0 0", D_pc, D_instr, D_exc); end
        tick();
        checks++; if (D_pc !== 32'h3000 || i_addr !== 32'h3004) begin errors++; $display("FAIL reset_first: D_pc %h i_addr %h want 3000 3004", D_pc, i_addr); end
        checks++; if (D_instr !== 32'hC0DE_3000 || D_valid !== 1'b1) begin errors++; $display("FAIL reset_first_instr: %h/%b want c0de3000/1", D_instr, D_valid); end
    endtask

    task automatic test_branch();
        restart(3);  // F=300C, D=3008
        npc_sel = 2'b01; br_taken = 1'b1; br_offset = 32'hFFFF_FFFE;
        tick();
        checks++; if (D_pc !== 32'h300C || i_addr !== 32'h3004) begin errors++; $display("FAIL branch_taken: D_pc %h i_addr %h want 300c 3004", D_pc, i_addr); end
        checks++; if (D_instr !== 32'hC0DE_300C) begin errors++; $display("FAIL branch_slot_instr: got %h want c0de300c", D_instr); end
        // Not taken, D=300C, F=3004: the PC advances sequentially.
        br_taken = 1'b0;
        tick();
        checks++; if (i_addr !== 32'h3008 || D_pc !== 32'h3004) begin errors++; $display("FAIL branch_not_taken: i_addr %h D_pc %h want 3008 3004", i_addr, D_pc); end
        // Forward taken branch from D=3004: 3008 + 0x10*4 = 3048.
        br_taken = 1'b1; br_offset = 32'h0000_0010;
        tick();
        checks++; if (i_addr !== 32'h3048) begin errors++; $display("FAIL branch_fwd: got %h want 3048", i_addr); end
    endtask

    task automatic test_jump();
        restart(5);  // F=3014, D=3010 holding 0800_1000
        checks++; if (D_instr !== 32'h0800_1000 || D_imm16 !== 16'h1000) begin errors++; $display("FAIL jump_dinstr: %h/%h want 08001000/1000", D_instr, D_imm16); end
        npc_sel = 2'b10;
        tick();
        checks++; if (i_addr !== 32'h4000 || D_pc !== 32'h3014) begin errors++; $display("FAIL jump: i_addr %h D_pc %h want 4000 3014", i_addr, D_pc); end
    endtask

    task automatic test_stall_flush();
        restart(3);  // F=300C, D=3008
        stall = 1'b1; flush = 1'b1; npc_sel = 2'b11; jr_target = 32'h5000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (i_addr !== 32'h300C || D_pc !== 32'h3008 || D_instr !== 32'hC0DE_3008 || D_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: F %h Dpc %h Di %h v %b want 300c 3008 c0de3008 1", i, i_addr, D_pc, D_instr, D_valid);
            end
        end
        idle_inputs();
        tick();
        checks++; if (i_addr !== 32'h3010 || D_pc !== 32'h300C || D_valid !== 1'b1) begin errors++; $display("FAIL stall_release: F %h Dpc %h v %b want 3010 300c 1", i_addr, D_pc, D_valid); end
    endtask

    task automatic test_flush();
        restart(8);  // F=3020
        flush = 1'b1;
        tick();
        checks++; if (D_instr !== 32'h0 || D_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble: %h/%b want 0/0", D_instr, D_valid); end
        checks++; if (D_pc !== 32'h3020 || i_addr !== 32'h3024) begin errors++; $display("FAIL flush_pc: Dpc %h F %h want 3020 3024", D_pc, i_addr); end
    endtask

    task automatic test_reset_mid_stall();
        restart(4);
        stall = 1'b1; npc_sel = 2'b11; jr_target = 32'h6000;
        reset = 1'b1;
        tick();
        idle_inputs();
        checks++; if (i_addr !== 32'h3000 || D_valid !== 1'b0 || D_pc !== 32'h0) begin errors++; $display("FAIL reset_mid_stall: F %h v %b Dpc %h want 3000 0 0", i_addr, D_valid, D_pc); end
    endtask

    task automatic test_adel();
        logic [31:0] exp_instr;
        logic        exp_exc;
        restart(1);  // F=3004
        npc_sel = 2'b11; jr_target = 32'h3002;
        tick();
        checks++; if (i_addr !== 32'h3002) begin errors++; $display("FAIL jr_target: got %h want 3002", i_addr); end
        npc_sel = 2'b00;
        tick();
`ifdef FETCH_ADEL_CHECK_EN
        exp_exc = 1'b1; exp_instr = 32'h0;
`else
        exp_exc = 1'b0; exp_instr = 32'hC0DE_3002;
`endif
        checks++; if (D_exc !== exp_exc || D_instr !== exp_instr) begin errors++; $display("FAIL adel_misalign: exc %b instr %h want %b %h", D_exc, D_instr, exp_exc, exp_instr); end
        checks++; if (D_pc !== 32'h3002 || D_valid !== 1'b1 || i_addr !== 32'h3006) begin errors++; $display("FAIL adel_pc: Dpc %h v %b F %h want 3002 1 3006", D_pc, D_valid, i_addr); end
        // Aligned, but just above the upper bound.
        npc_sel = 2'b11; jr_target = 32'h7000;
        tick();
        npc_sel = 2'b00;
        tick();
`ifdef FETCH_ADEL_CHECK_EN
        exp_exc = 1'b1; exp_instr = 32'h0;
`else
        exp_exc = 1'b0; exp_instr = 32'hC0DE_7000;
`endif
        checks++; if (D_exc !== exp_exc || D_instr !== exp_instr) begin errors++; $display("FAIL adel_range: exc %b instr %h want %b %h", D_exc, D_instr, exp_exc, exp_instr); end
        // Top in-range word: no fault.
        npc_sel = 2'b11; jr_target = 32'h6FFC;
        tick();
        npc_sel = 2'b00;
        tick();
        checks++; if (D_exc !== 1'b0 || D_instr !== 32'hC0DE_6FFC) begin errors++; $display("FAIL adel_edge_ok: exc %b instr %h want 0 c0de6ffc", D_exc, D_instr); end
    endtask

    task automatic test_wrap();
        restart(0);
        npc_sel = 2'b11; jr_target = 32'hFFFF_FFFC;
        tick();
        npc_sel = 2'b00;
        tick();
        checks++; if (i_addr !== 32'h0 || D_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL pc_wrap: F %h Dpc %h want 0 fffffffc", i_addr, D_pc); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_branch();
        test_jump();
        test_stall_flush();
        test_flush();
        test_reset_mid_stall();
        test_adel();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
